// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter
// Shares the single-port byte-addressable data RAM between the core
// load/store port (c_*) and the debug/loader port (d_*).
// Arbitration is round-robin. Every granted access runs through a fixed
// IDLE -> ACCESS -> DONE sequence. Out-of-range accesses and writes to the
// input-only IO word are rejected before they reach the RAM.
//
// Ports:
//   clk, reset            : clock; asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata : core request, held until c_ack
//   c_ack/c_err/c_rdata   : core completion pulse, reject flag, read data
//   d_*                   : same as the core port, for debug/loader
//   addr_bus, write_data_bus, write_signal : RAM address, data, write enable
//   read_data_bus         : RAM combinational read data
//   busy                  : sequencer is not in IDLE
module mem_data_arbiter #(
  parameter int unsigned MEM_BYTES   = 100,
  parameter int unsigned IO_IN_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  // core port
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic        c_err,
  output logic [31:0] c_rdata,
  // debug/loader port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  // RAM side
  output logic [31:0] addr_bus,
  output logic [31:0] write_data_bus,
  output logic        write_signal,
  input  logic [31:0] read_data_bus,
  output logic        busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Highest legal word start address and end of the input-only region
  localparam logic [AW-1:0] MAX_ADDR = AW'(MEM_BYTES - 4);
  localparam logic [AW-1:0] IO_LIMIT = AW'(IO_IN_BYTES);

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DBG  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Latched access fields
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          last_grant_q, last_grant_d;

  // Registered outputs
  logic          c_ack_q, c_ack_d;
  logic          c_err_q, c_err_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [AW-1:0] addr_bus_q, addr_bus_d;
  logic [DW-1:0] wdb_q, wdb_d;
  logic          ws_q, ws_d;
  logic          busy_q, busy_d;

  // Request selection
  logic          grant_any;
  logic          grant_dbg;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;

  // Round-robin pick: on a tie the port that did not win last time goes
  always_comb begin
    grant_any = c_req | d_req;
    grant_dbg = d_req & (~c_req | (last_grant_q == OWNER_CORE));
    sel_we    = grant_dbg ? d_we    : c_we;
    sel_addr  = grant_dbg ? d_addr  : c_addr;
    sel_wdata = grant_dbg ? d_wdata : c_wdata;
    // Unsigned compare, so wrapped addresses near 2^32 are rejected too
    sel_err   = (sel_addr > MAX_ADDR) | (sel_we & (sel_addr < IO_LIMIT));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (grant_any) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and latch next-values, decoded from state, latched fields and the grant
  always_comb begin
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    c_ack_d      = 1'b0;
    c_err_d      = 1'b0;
    c_rdata_d    = c_rdata_q;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    addr_bus_d   = '0;
    wdb_d        = '0;
    ws_d         = 1'b0;
    busy_d       = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          owner_d      = grant_dbg ? OWNER_DBG : OWNER_CORE;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          err_d        = sel_err;
          last_grant_d = grant_dbg ? OWNER_DBG : OWNER_CORE;
          // RAM-side outputs for the coming ACCESS cycle; rejected accesses stay at 0
          if (!sel_err) begin
            addr_bus_d = sel_addr;
            if (sel_we) begin
              wdb_d = sel_wdata;
              ws_d  = 1'b1;
            end
          end
        end
      end
      S_ACCESS: begin
        // Read data captured at the end of ACCESS; rejected accesses return 0
        if (owner_q == OWNER_CORE) begin
          if (err_q)      c_rdata_d = '0;
          else if (!we_q) c_rdata_d = read_data_bus;
          c_ack_d = 1'b1;
          c_err_d = err_q;
        end else begin
          if (err_q)      d_rdata_d = '0;
          else if (!we_q) d_rdata_d = read_data_bus;
          d_ack_d = 1'b1;
          d_err_d = err_q;
        end
      end
      default: ;
    endcase
  end

  // Latched fields and registered outputs; reset clears write_signal immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= OWNER_CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      last_grant_q <= OWNER_DBG;
      c_ack_q      <= 1'b0;
      c_err_q      <= 1'b0;
      c_rdata_q    <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      addr_bus_q   <= '0;
      wdb_q        <= '0;
      ws_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      c_ack_q      <= c_ack_d;
      c_err_q      <= c_err_d;
      c_rdata_q    <= c_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      addr_bus_q   <= addr_bus_d;
      wdb_q        <= wdb_d;
      ws_q         <= ws_d;
      busy_q       <= busy_d;
    end
  end

  assign c_ack          = c_ack_q;
  assign c_err          = c_err_q;
  assign c_rdata        = c_rdata_q;
  assign d_ack          = d_ack_q;
  assign d_err          = d_err_q;
  assign d_rdata        = d_rdata_q;
  assign addr_bus       = addr_bus_q;
  assign write_data_bus = wdb_q;
  assign write_signal   = ws_q;
  assign busy           = busy_q;

endmodule
